// File: rtl/multicycle_ctrl.sv
// Main control FSM for the RV32I multicycle datapath.
// Sequences the shared memory, ALU and holding registers per opcode.
module multicycle_ctrl #(
   parameter int                 STATE_W     = 4,
   parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7_5,
   input  logic               Zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               MemWrite,
   output logic               AdrSrc,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [3:0]         ALUControl,
   output logic [2:0]         ImmSrc,
   output logic               instret,
   output logic               illegal_instr,
   output logic [STATE_W-1:0] dbg_state
);

   localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
   localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
   localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
   localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
   localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
   localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
   localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
   localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
   localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
   localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
   localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
   localparam logic [STATE_W-1:0] S_JALR_EX  = STATE_W'(11);
   localparam logic [STATE_W-1:0] S_JALR_PC  = STATE_W'(12);
   localparam logic [STATE_W-1:0] S_LUI      = STATE_W'(13);
   localparam logic [STATE_W-1:0] S_AUIPC    = STATE_W'(14);
   localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(15);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLT   = 4'd5;
   localparam logic [3:0] ALU_SLTU  = 4'd6;
   localparam logic [3:0] ALU_SLL   = 4'd7;
   localparam logic [3:0] ALU_SRL   = 4'd8;
   localparam logic [3:0] ALU_SRA   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;
   logic [STATE_W-1:0] w_dec_next;
   logic [3:0]         w_exec_alu;
   logic [3:0]         w_br_alu;
   logic               w_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RESET_STATE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_dec_next = S_TRAP;
      case (op)
         OP_LOAD, OP_STORE: w_dec_next = S_MEMADR;
         OP_R:              w_dec_next = S_EXECR;
         OP_I:              w_dec_next = S_EXECI;
         OP_JAL:            w_dec_next = S_JAL;
         OP_LUI:            w_dec_next = S_LUI;
         OP_AUIPC:          w_dec_next = S_AUIPC;
         OP_BRANCH:
            if (funct3[2:1] != 2'b01) w_dec_next = S_BRANCH;
         OP_JALR:
            if (funct3 == 3'b000) w_dec_next = S_JALR_EX;
         default:           w_dec_next = S_TRAP;
      endcase
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_FETCH:    if (mem_ready) w_next = S_DECODE;
         S_DECODE:   w_next = w_dec_next;
         S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
         S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
         S_MEMWB, S_ALUWB, S_BRANCH, S_JALR_PC:
            w_next = S_FETCH;
         S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC:
            w_next = S_ALUWB;
         S_JALR_EX:  w_next = S_JALR_PC;
         S_TRAP:     w_next = S_TRAP;
         default:    w_next = S_TRAP;
      endcase
   end

   // SUB needs both the R-type form and funct7_5; addi ignores bit 30
   always_comb begin
      w_exec_alu = ALU_ADD;
      unique case (funct3)
         3'b000: w_exec_alu = (r_state == S_EXECR && funct7_5) ?
                              ALU_SUB : ALU_ADD;
         3'b001: w_exec_alu = ALU_SLL;
         3'b010: w_exec_alu = ALU_SLT;
         3'b011: w_exec_alu = ALU_SLTU;
         3'b100: w_exec_alu = ALU_XOR;
         3'b101: w_exec_alu = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110: w_exec_alu = ALU_OR;
         3'b111: w_exec_alu = ALU_AND;
         default: w_exec_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      w_br_alu = ALU_SUB;
      w_taken  = !Zero;
      unique case (funct3[2:1])
         2'b10:   w_br_alu = ALU_SLT;
         2'b11:   w_br_alu = ALU_SLTU;
         default: w_br_alu = ALU_SUB;
      endcase
      unique case (funct3)
         3'b000, 3'b101, 3'b111: w_taken = Zero;
         default:                w_taken = !Zero;
      endcase
   end

   always_comb begin
      mem_req       = 1'b0;
      MemWrite      = 1'b0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUControl    = ALU_ADD;
      ImmSrc        = IMM_I;
      instret       = 1'b0;
      illegal_instr = 1'b0;
      if (rst_n) begin
         unique case (r_state)
            S_FETCH: begin
               mem_req   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
            end
            S_DECODE: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
               ImmSrc  = (op == OP_BRANCH) ? IMM_B : IMM_J;
            end
            S_MEMADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ImmSrc  = op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
               mem_req = 1'b1;
               AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
               ResultSrc = 2'b01;
               RegWrite  = 1'b1;
               instret   = 1'b1;
            end
            S_MEMWRITE: begin
               mem_req  = 1'b1;
               MemWrite = 1'b1;
               AdrSrc   = 1'b1;
               instret  = mem_ready;
            end
            S_EXECR, S_EXECI: begin
               ALUSrcA    = 2'b10;
               ALUSrcB    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
               ALUControl = w_exec_alu;
            end
            S_ALUWB: begin
               RegWrite = 1'b1;
               instret  = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA    = 2'b10;
               ALUControl = w_br_alu;
               PCWrite    = w_taken;
               instret    = 1'b1;
            end
            S_JAL: begin
               PCWrite = 1'b1;
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
            end
            S_JALR_EX: begin
               ALUSrcA   = 2'b10;
               ALUSrcB   = 2'b01;
               RegWrite  = 1'b1;
               ResultSrc = 2'b11;
            end
            S_JALR_PC: begin
               PCWrite = 1'b1;
               instret = 1'b1;
            end
            S_LUI: begin
               ALUSrcB    = 2'b01;
               ImmSrc     = IMM_U;
               ALUControl = ALU_PASSB;
            end
            S_AUIPC: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
               ImmSrc  = IMM_U;
            end
            S_TRAP:  illegal_instr = 1'b1;
            default: illegal_instr = 1'b0;
         endcase
      end
   end

   assign dbg_state = rst_n ? r_state : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table, scoreboard queue
// between the driver and a monitor sampling mid-cycle.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       mem_req, mw, adr, irw, pcw, rw;
      logic [1:0] rs, sa, sb;
      logic [3:0] alu;
      logic [2:0] imm;
      logic       ir, ill;
      logic [3:0] st;
   } out_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, z, rdy, rstn;
      out_t       e;
   } vec_t;

   typedef struct {
      int   idx;
      out_t e;
   } sb_t;

   localparam logic [6:0] LD = 7'h03, ST = 7'h23, RR = 7'h33, RI = 7'h13;
   localparam logic [6:0] BR = 7'h63, JL = 7'h6F, JR = 7'h67;
   localparam logic [6:0] LU = 7'h37, AU = 7'h17, BAD = 7'h7F;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic       funct7_5 = 1'b0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;

   logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [3:0] ALUControl;
   logic [2:0] ImmSrc;
   logic       instret, illegal_instr;
   logic [3:0] dbg_state;

   vec_t tbl[$];
   sb_t  sbq[$];
   int   n_pass = 0;
   int   n_total = 0;
   logic [6:0] c_op;
   logic [2:0] c_f3;
   logic       c_f7;

   multicycle_ctrl #(.STATE_W(4), .RESET_STATE(4'd0)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
      .funct7_5(funct7_5), .Zero(Zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instret(instret),
      .illegal_instr(illegal_instr), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic out_t o(input logic [3:0] st, input logic [5:0] ctl,
                              input logic [1:0] rs, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [3:0] alu,
                              input logic [2:0] imm, input logic ir,
                              input logic ill);
      out_t r;
      {r.mem_req, r.mw, r.adr, r.irw, r.pcw, r.rw} = ctl;
      r.rs = rs; r.sa = sa; r.sb = sb; r.alu = alu;
      r.imm = imm; r.ir = ir; r.ill = ill; r.st = st;
      return r;
   endfunction

   task automatic instr(input logic [6:0] p, input logic [2:0] f,
                        input logic f7);
      c_op = p; c_f3 = f; c_f7 = f7;
   endtask

   task automatic put(input logic z, input logic rdy, input logic rstn,
                      input out_t e);
      vec_t v;
      v.op = c_op; v.f3 = c_f3; v.f7 = c_f7;
      v.z = z; v.rdy = rdy; v.rstn = rstn; v.e = e;
      tbl.push_back(v);
   endtask

   task automatic fetch(input logic rdy);
      put(0, rdy, 1, o(0, rdy ? 6'b100110 : 6'b100000,
                       2, 0, 2, 0, 0, 0, 0));
   endtask

   task automatic decode(input logic [2:0] imm);
      put(0, 1, 1, o(1, 0, 0, 1, 1, 0, imm, 0, 0));
   endtask

   task automatic aluwb();
      put(0, 1, 1, o(8, 6'b000001, 0, 0, 0, 0, 0, 1, 0));
   endtask

   task automatic rst();
      put(0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic trap(input int n);
      for (int k = 0; k < n; k++)
         put(0, 1, 1, o(15, 0, 0, 0, 0, 0, 0, 0, 1));
   endtask

   task automatic exec(input logic [6:0] p, input logic [2:0] f,
                       input logic f7, input logic [3:0] alu);
      instr(p, f, f7);
      fetch(1);
      decode(3);
      if (p == RR) put(0, 1, 1, o(6, 0, 0, 2, 0, alu, 0, 0, 0));
      else         put(0, 1, 1, o(7, 0, 0, 2, 1, alu, 0, 0, 0));
      aluwb();
   endtask

   task automatic branch(input logic [2:0] f, input logic z,
                         input logic [3:0] alu, input logic pcw);
      instr(BR, f, 0);
      fetch(1);
      decode(2);
      put(z, 1, 1, o(9, pcw ? 6'b000010 : 6'b0, 0, 2, 0, alu, 0, 1, 0));
   endtask

   initial begin : monitor
      sb_t  s;
      out_t act;
      forever begin
         @(negedge clk);
         #2;
         if (sbq.size() > 0) begin
            s = sbq.pop_front();
            act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
                   instret, illegal_instr, dbg_state};
            n_total++;
            if (act === s.e) n_pass++;
            else
               $display("FAIL step %0d outputs: got %h required %h (state got %0d required %0d)",
                        s.idx, act, s.e, act.st, s.e.st);
         end
      end
   end

   initial begin : driver
      instr(0, 0, 0);
      rst(); rst();

      exec(RR, 0, 0, 0);
      exec(RR, 0, 1, 1);
      exec(RR, 5, 1, 9);
      exec(RR, 5, 0, 8);
      exec(RR, 1, 0, 7);
      exec(RR, 2, 0, 5);
      exec(RR, 3, 0, 6);
      exec(RR, 4, 0, 4);
      exec(RR, 6, 0, 3);
      exec(RR, 7, 0, 2);
      exec(RI, 0, 1, 0);
      exec(RI, 5, 1, 9);
      exec(RI, 5, 0, 8);
      exec(RI, 2, 0, 5);
      exec(RI, 7, 0, 2);

      // lw with two wait states in both FETCH and MEMREAD: 9 cycles
      instr(LD, 2, 0);
      fetch(0); fetch(0); fetch(1);
      decode(3);
      put(0, 1, 1, o(2, 0, 0, 2, 1, 0, 0, 0, 0));
      put(0, 0, 1, o(3, 6'b101000, 0, 0, 0, 0, 0, 0, 0));
      put(0, 0, 1, o(3, 6'b101000, 0, 0, 0, 0, 0, 0, 0));
      put(0, 1, 1, o(3, 6'b101000, 0, 0, 0, 0, 0, 0, 0));
      put(0, 1, 1, o(4, 6'b000001, 1, 0, 0, 0, 0, 1, 0));

      instr(ST, 2, 0);
      fetch(1);
      decode(3);
      put(0, 1, 1, o(2, 0, 0, 2, 1, 0, 1, 0, 0));
      put(0, 0, 1, o(5, 6'b111000, 0, 0, 0, 0, 0, 0, 0));
      put(0, 1, 1, o(5, 6'b111000, 0, 0, 0, 0, 0, 1, 0));

      branch(0, 1, 1, 1);
      branch(0, 0, 1, 0);
      branch(4, 0, 5, 1);
      branch(1, 1, 1, 0);
      branch(5, 0, 5, 0);
      branch(6, 0, 6, 1);
      branch(7, 1, 6, 1);

      instr(JL, 0, 0);
      fetch(1); decode(3);
      put(0, 1, 1, o(10, 6'b000010, 0, 1, 2, 0, 0, 0, 0));
      aluwb();

      instr(JR, 0, 0);
      fetch(1); decode(3);
      put(0, 1, 1, o(11, 6'b000001, 3, 2, 1, 0, 0, 0, 0));
      put(0, 1, 1, o(12, 6'b000010, 0, 0, 0, 0, 0, 1, 0));

      instr(LU, 0, 0);
      fetch(1); decode(3);
      put(0, 1, 1, o(13, 0, 0, 0, 1, 10, 4, 0, 0));
      aluwb();

      instr(AU, 0, 0);
      fetch(1); decode(3);
      put(0, 1, 1, o(14, 0, 0, 1, 1, 0, 4, 0, 0));
      aluwb();

      // reset lands while MEMREAD is stalled
      instr(LD, 2, 0);
      fetch(1); decode(3);
      put(0, 1, 1, o(2, 0, 0, 2, 1, 0, 0, 0, 0));
      put(0, 0, 1, o(3, 6'b101000, 0, 0, 0, 0, 0, 0, 0));
      rst();
      fetch(0);
      fetch(1);

      instr(BAD, 0, 0);
      decode(3);
      trap(20);
      rst();
      fetch(1);

      instr(BR, 2, 0);
      decode(2);
      trap(3);
      rst();

      instr(JR, 1, 0);
      fetch(1); decode(3);
      trap(2);
      rst();
      fetch(1);

      for (int i = 0; i < tbl.size(); i++) begin
         sb_t s;
         @(negedge clk);
         op = tbl[i].op; funct3 = tbl[i].f3; funct7_5 = tbl[i].f7;
         Zero = tbl[i].z; mem_ready = tbl[i].rdy; rst_n = tbl[i].rstn;
         s.idx = i; s.e = tbl[i].e;
         sbq.push_back(s);
      end
      repeat (2) @(negedge clk);
      #3;
      if (sbq.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard drain: got %0d pending required 0",
                  sbq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM that sequences the RV32I multicycle datapath: one shared instruction/data memory and one ALU reused across cycles, plus the IR, OldPC, A/B, ALUOut and Data holding registers. It decodes the opcode in the IR and drives all datapath selects and enables state by state. It also runs a req/ready handshake with the shared memory, so wait states are tolerated. Illegal encodings are trapped.

Parameters:
STATE_W, 4, width of the state register and of the dbg_state port
RESET_STATE, 4'd0, state entered on reset (FETCH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  IR[6:0]
funct3  input  3  IR[14:12]
funct7_5  input  1  IR[30]
Zero  input  1  ALU zero flag, current cycle
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
MemWrite  output  1  write qualifier for mem_req
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
IRWrite  output  1  load IR and OldPC
PCWrite  output  1  load PC from Result
RegWrite  output  1  register file write enable
ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = PC
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A
ALUSrcB  output  2  00 = B, 01 = ImmExt, 10 = constant 4
ALUControl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASSB
ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
instret  output  1  one-cycle pulse when an instruction retires
illegal_instr  output  1  high while in TRAP
dbg_state  output  STATE_W  current state

Behaviour:
- Reset and output defaults:
  - rst_n=0 sets state to FETCH asynchronously. While rst_n=0, all outputs are forced to 0.
  - Outputs are combinational from state, op, funct3, funct7_5, Zero and mem_ready.
  - Any output not listed for a state is 0.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR_EX 11, JALR_PC 12, LUI 13, AUIPC 14, TRAP 15.
- FETCH:
  - mem_req=1, AdrSrc=0, SrcA=PC, SrcB=4, ADD, ResultSrc=10.
  - IRWrite and PCWrite are both equal to mem_ready.
  - Stays in FETCH while mem_ready=0. Goes to DECODE on mem_ready=1.
- DECODE:
  - SrcA=OldPC, SrcB=Imm, ADD, so ALUOut receives the branch/JAL target. ImmSrc is B for op 1100011, J otherwise.
  - Next state by op:
    - 0000011 or 0100011: MEMADR
    - 0110011: EXECR
    - 0010011: EXECI
    - 1100011: BRANCH
    - 1101111: JAL
    - 1100111 with funct3=000: JALR_EX
    - 0110111: LUI
    - 0010111: AUIPC
    - anything else: TRAP
- MEMADR: SrcA=A, SrcB=Imm, ADD. ImmSrc is S for stores, I for loads. Next is MEMWRITE for stores, MEMREAD for loads.
- MEMREAD: mem_req=1, AdrSrc=1. Waits on mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instret=1. Next FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. instret=mem_ready. Next is FETCH when mem_ready=1.
- EXECR / EXECI:
  - SrcA=A. SrcB is B for EXECR, Imm for EXECI (ImmSrc I). Next ALUWB.
  - ALU decode by funct3:
    - 000: ADD; SUB only in EXECR with funct7_5=1
    - 001: SLL
    - 010: SLT
    - 011: SLTU
    - 100: XOR
    - 101: SRA if funct7_5=1, else SRL (both forms)
    - 110: OR
    - 111: AND
- ALUWB: ResultSrc=00, RegWrite=1, instret=1. Next FETCH.
- BRANCH:
  - SrcA=A, SrcB=B, ResultSrc=00.
  - ALU op by funct3: SUB for 000/001, SLT for 100/101, SLTU for 110/111.
  - taken is Zero for 000, 101 and 111; taken is !Zero for 001, 100 and 110.
  - PCWrite=taken, instret=1. Next FETCH.
  - funct3 010 or 011 in DECODE goes to TRAP instead of BRANCH.
- JAL: ResultSrc=00, PCWrite=1, SrcA=OldPC, SrcB=4, ADD, so ALUOut receives the link. Next ALUWB.
- JALR_EX: SrcA=A, SrcB=Imm (ImmSrc I), ADD. RegWrite=1 with ResultSrc=11 writes the link (PC = OldPC+4). A was latched in DECODE, so rd==rs1 is safe. Next JALR_PC.
- JALR_PC: ResultSrc=00, PCWrite=1, instret=1. The datapath clears bit 0. Next FETCH.
- LUI: SrcB=Imm, ImmSrc U, PASSB. Next ALUWB.
- AUIPC: SrcA=OldPC, SrcB=Imm, ImmSrc U, ADD. Next ALUWB.
- TRAP: illegal_instr=1, no writes, no requests. Stays in TRAP until rst_n=0.
- Reset mid-access: mem_req drops in the same cycle. Memory must discard the access. FETCH restarts after release.
- Cycle counts (zero wait states): R/I/LUI/AUIPC/JAL 4, load 5, store 4, branch 3, JALR 4. Each wait state adds one cycle to FETCH, MEMREAD or MEMWRITE.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready always 1 -> states 0,1,6,8. RegWrite=1, ResultSrc=00 in cycle 4. instret=1 once.
- lw x5,8(x1) with mem_ready low 2 cycles in both FETCH and MEMREAD -> 9 cycles total. IRWrite=1 only on the ready cycle. RegWrite with ResultSrc=01 in MEMWB.
- beq, then blt -> beq: Zero=1 gives PCWrite=1, Zero=0 gives PCWrite=0. blt (funct3=100): ALUControl=0101, Zero=0 gives PCWrite=1.
- jalr x1,4(x1) -> JALR_EX has RegWrite=1, ResultSrc=11, ALUControl=0000. JALR_PC has PCWrite=1, ResultSrc=00. Next state FETCH.
- op=0x7F, or branch funct3=010 -> TRAP (15), illegal_instr=1, held 20 cycles. rst_n pulse returns to FETCH.
- rst_n asserted during MEMREAD wait -> mem_req=0 immediately and dbg_state=0. After release, FETCH with mem_req=1.
